// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staggered multi-domain reset sequencer with minimum-width assertion and hold
module rst_seq #(
    parameter int N_DOM      = 3,
    parameter int ASSERT_CYC = 16,
    parameter int STAGE_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             hold,
    output logic [N_DOM-1:0] rst_n_o,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(ASSERT_CYC);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int KW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(ASSERT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N_DOM - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    g_q, g_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N_DOM-1:0] rst_n_q, rst_n_d;
    logic             done_q, done_d;
    logic             start_rel;

    // State and output registers; reset restarts a full assertion window
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            g_q     <= '0;
            k_q     <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            k_q     <= k_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a request overrides every other transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        k_d       = k_q;
        rst_n_d   = rst_n_q;
        done_d    = 1'b0;
        start_rel = 1'b0;

        case (state_q)
            S_ASSERT: begin
                rst_n_d = '0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (hold) begin
                        state_d = S_HOLD;
                    end else begin
                        start_rel = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                rst_n_d = '0;
                if (!hold) begin
                    start_rel = 1'b1;
                end
            end
            S_RELEASE: begin
                g_d = g_q + GW'(1);
                if (g_q == GAP_LAST) begin
                    rst_n_d = rst_n_q | (N_DOM'(1) << k_q);
                    g_d     = '0;
                    k_d     = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                rst_n_d = '1;
            end
        endcase

        // Bit 0 leaves reset on the edge that ends assertion or hold
        if (start_rel) begin
            if (N_DOM == 1) begin
                state_d = S_IDLE;
                rst_n_d = '1;
                done_d  = 1'b1;
            end else begin
                state_d = S_RELEASE;
                rst_n_d = N_DOM'(1);
                k_d     = KW'(1);
                g_d     = '0;
            end
        end

        if (req) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            g_d     = '0;
            k_d     = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end
    end

    assign rst_n_o = rst_n_q;
    assign done    = done_q;
    assign busy    = ~&rst_n_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - table-driven self-checking bench for rst_seq
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       hold;
    logic [2:0] rst_n_o;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req;
        logic       hold;
        logic [2:0] rn;
        logic       dn;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    rst_seq #(.N_DOM(3), .ASSERT_CYC(16), .STAGE_GAP(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .hold    (hold),
        .rst_n_o (rst_n_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] rn, input logic dn);
        chk({name, ".rst_n_o"}, 32'(rst_n_o), 32'(rn));
        chk({name, ".busy"}, 32'(busy), 32'(rn != 3'b111));
        chk({name, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic add(input int n, input logic r, input logic h, input logic [2:0] rn,
                       input logic dn, input string tag);
        vec_t v;
        v.req  = r;
        v.hold = h;
        v.rn   = rn;
        v.dn   = dn;
        v.tag  = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // After the last rst-high edge: edge j=0 is the first rst-low edge r
    task automatic post_reset_seq(input string name);
        logic [2:0] rn;
        rst = 1'b0;
        for (int j = 0; j < 28; j++) begin
            tick();
            rn = (j < 15) ? 3'b000 : (j < 19) ? 3'b001 : (j < 23) ? 3'b011 : 3'b111;
            chk_all($sformatf("%s.j%0d", name, j), rn, j == 23);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        hold = 1'b0;

        // Power-on
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("por_rst", 3'b000, 1'b0);
        end
        post_reset_seq("por");

        // Single request from idle
        add(1, 1, 0, 3'b000, 0, "single");
        add(15, 0, 0, 3'b000, 0, "single");
        add(4, 0, 0, 3'b001, 0, "single");
        add(4, 0, 0, 3'b011, 0, "single");
        add(1, 0, 0, 3'b111, 1, "single");
        add(3, 0, 0, 3'b111, 0, "single");
        // Hold high at end of assertion, released on edge t+41
        add(1, 1, 0, 3'b000, 0, "hold");
        add(9, 0, 0, 3'b000, 0, "hold");
        add(31, 0, 1, 3'b000, 0, "hold");
        add(4, 0, 0, 3'b001, 0, "hold");
        add(4, 0, 0, 3'b011, 0, "hold");
        add(1, 0, 0, 3'b111, 1, "hold");
        add(3, 0, 0, 3'b111, 0, "hold");
        // Second request while bit 0 already released
        add(1, 1, 0, 3'b000, 0, "midrel");
        add(15, 0, 0, 3'b000, 0, "midrel");
        add(2, 0, 0, 3'b001, 0, "midrel");
        add(1, 1, 0, 3'b000, 0, "midrel");
        add(15, 0, 0, 3'b000, 0, "midrel");
        add(4, 0, 0, 3'b001, 0, "midrel");
        add(4, 0, 0, 3'b011, 0, "midrel");
        add(1, 0, 0, 3'b111, 1, "midrel");
        add(2, 0, 0, 3'b111, 0, "midrel");
        // Request coinciding with the release edge
        add(1, 1, 0, 3'b000, 0, "reledge");
        add(15, 0, 0, 3'b000, 0, "reledge");
        add(1, 1, 0, 3'b000, 0, "reledge");
        add(15, 0, 0, 3'b000, 0, "reledge");
        add(4, 0, 0, 3'b001, 0, "reledge");
        add(4, 0, 0, 3'b011, 0, "reledge");
        add(1, 0, 0, 3'b111, 1, "reledge");
        add(2, 0, 0, 3'b111, 0, "reledge");

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            hold = vecs[i].hold;
            tick();
            chk_all($sformatf("%s.v%0d", vecs[i].tag, i), vecs[i].rn, vecs[i].dn);
        end
        req  = 1'b0;
        hold = 1'b0;

        // Reset pulsed mid-release while rst_n_o=011
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        chk_all("midrst_pre", 3'b011, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("midrst_rst", 3'b000, 1'b0);
        post_reset_seq("midrst");

        // rst has priority over req
        rst = 1'b1;
        req = 1'b1;
        tick();
        chk_all("rst_prio", 3'b000, 1'b0);
        req = 1'b0;
        post_reset_seq("rst_prio");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
